// File: rtl/hann_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hann_frame_sequencer_if
// Brief    : Sample-in, coefficient-ROM and windowed-out buses of the sequencer.
// Revision : 1.0
// ============================================================================
interface hann_frame_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int COEF_WIDTH   = 16,
    parameter int SAMPLE_COUNT = 4096
);
    localparam int ADDR_WIDTH = $clog2(SAMPLE_COUNT);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_sample;

    logic                  coef_en;
    logic [ADDR_WIDTH-1:0] coef_addr;
    logic [COEF_WIDTH-1:0] coef_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_sample;
    logic                  out_last;

    modport master (
        input  in_valid, in_sample, coef_data, out_ready,
        output in_ready, coef_en, coef_addr, out_valid, out_sample, out_last
    );

    modport slave (
        output in_valid, in_sample, coef_data, out_ready,
        input  in_ready, coef_en, coef_addr, out_valid, out_sample, out_last
    );
endinterface
`default_nettype wire

// File: rtl/hann_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hann_frame_sequencer
// Brief    : Frame controller and two-stage Hann windowing pipeline with ROM.
// Revision : 1.0
// ============================================================================
module hann_frame_sequencer #(
    parameter int DATA_WIDTH      = 8,
    parameter int COEF_WIDTH      = 16,
    parameter int SAMPLE_COUNT    = 4096,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  wire                        clk_in,
    input  wire                        rst_in,
    input  wire                        start_in,
    input  wire                        stop_in,
    input  wire  [FRAME_CNT_WIDTH-1:0] num_frames_in,
    hann_frame_sequencer_if.master     bus,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frames_done
);
    localparam int ADDR_WIDTH = $clog2(SAMPLE_COUNT);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_INDEX = ADDR_WIDTH'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_WIDTH-1:0]      r_index;
    logic [FRAME_CNT_WIDTH-1:0] r_frames_target;
    logic [FRAME_CNT_WIDTH-1:0] r_frames_in;
    logic [FRAME_CNT_WIDTH-1:0] r_frames_done;
    logic                       r_stop_pending;

    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic [DATA_WIDTH-1:0]      r_s1_sample;
    logic                       r_coef_live;
    logic [COEF_WIDTH-1:0]      r_s1_coef;

    logic                       r_out_valid;
    logic                       r_out_last;
    logic [DATA_WIDTH-1:0]      r_out_sample;

    logic                       w_advance;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_accept_last;
    logic                       w_frames_reached;
    logic                       w_out_last_hs;
    logic                       w_start;
    logic [COEF_WIDTH-1:0]      w_coef;
    logic [PROD_WIDTH-1:0]      w_product;

    assign w_advance        = !r_out_valid || bus.out_ready;
    assign w_in_ready       = (r_state == ST_RUN) && w_advance;
    assign w_accept         = w_in_ready && bus.in_valid;
    assign w_accept_last    = w_accept && (r_index == C_LAST_INDEX);
    assign w_frames_reached = (r_frames_target != '0) &&
                              (r_frames_in == r_frames_target - FRAME_CNT_WIDTH'(1));
    assign w_out_last_hs    = r_out_valid && bus.out_ready && r_out_last;
    assign w_start          = (r_state == ST_IDLE) && start_in;

    // ROM data is live only on the cycle after a read; a stall in that cycle is
    // bridged by the captured copy so the ROM is never re-read.
    assign w_coef    = r_coef_live ? bus.coef_data : r_s1_coef;
    assign w_product = PROD_WIDTH'(r_s1_sample) * PROD_WIDTH'(w_coef);

    assign bus.in_ready   = w_in_ready;
    assign bus.coef_en    = w_accept;
    assign bus.coef_addr  = r_index;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sample = r_out_sample;
    assign bus.out_last   = r_out_last;
    assign busy           = (r_state != ST_IDLE);
    assign frames_done    = r_frames_done;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept_last && (w_frames_reached || r_stop_pending || stop_in)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_last_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_index         <= '0;
            r_frames_target <= '0;
            r_frames_in     <= '0;
            r_frames_done   <= '0;
            r_stop_pending  <= 1'b0;
        end else if (w_start) begin
            r_index         <= '0;
            r_frames_target <= num_frames_in;
            r_frames_in     <= '0;
            r_frames_done   <= '0;
            r_stop_pending  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_index <= r_index + ADDR_WIDTH'(1);
            end
            if (w_accept_last) begin
                r_frames_in <= r_frames_in + FRAME_CNT_WIDTH'(1);
            end
            if (w_out_last_hs && (r_frames_done != '1)) begin
                r_frames_done <= r_frames_done + FRAME_CNT_WIDTH'(1);
            end
            if ((r_state == ST_RUN) && stop_in) begin
                r_stop_pending <= 1'b1;
            end else if ((r_state == ST_DRAIN) && (w_state_next == ST_IDLE)) begin
                r_stop_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_sample  <= '0;
            r_coef_live  <= 1'b0;
            r_s1_coef    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_sample <= '0;
        end else begin
            r_coef_live <= w_accept;
            if (r_coef_live) begin
                r_s1_coef <= bus.coef_data;
            end
            if (w_advance) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_sample <= bus.in_sample;
                    r_s1_last   <= w_accept_last;
                end
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_valid && r_s1_last;
                if (r_s1_valid) begin
                    r_out_sample <= DATA_WIDTH'(w_product >> COEF_WIDTH);
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hann_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hann_frame_sequencer
// Brief    : Self-checking bench: frame-level reference model plus vector table.
// Revision : 1.0
// ============================================================================
module tb_hann_frame_sequencer;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int N  = 8;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [FW-1:0] num_frames;
    logic          busy;
    logic [FW-1:0] frames_done;

    always #5 clk = ~clk;

    hann_frame_sequencer_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .SAMPLE_COUNT(N)) bus ();

    hann_frame_sequencer #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .SAMPLE_COUNT(N), .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start), .stop_in(stop),
        .num_frames_in(num_frames), .bus(bus), .busy(busy), .frames_done(frames_done)
    );

    typedef struct {
        logic [DW-1:0] s;
        logic          l;
    } out_t;

    typedef struct {
        int sample;
        int coef;
        int expv;
    } arith_t;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] rom [N];
    logic [CW-1:0] rom_q;
    int            cyc = 0;

    out_t          exp_q[$];
    logic          m_active = 1'b0;
    logic          m_accepting = 1'b0;
    int            m_acc_idx = 0;
    int            m_frames_in = 0;
    int            m_target = 0;
    logic          m_stop_pend = 1'b0;
    logic [FW-1:0] m_frames_done = '0;
    logic          prev_stall = 1'b0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] prev_sample = '0;
    int            n_out = 0;
    int            n_last = 0;
    int            first_acc_cyc = -1;
    int            first_out_cyc = -1;
    logic [DW-1:0] last_hs_sample = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active      = 1'b0;
        m_accepting   = 1'b0;
        m_acc_idx     = 0;
        m_frames_in   = 0;
        m_target      = 0;
        m_stop_pend   = 1'b0;
        m_frames_done = '0;
        prev_stall    = 1'b0;
    endtask

    // Called once per cycle after the inputs have settled.
    task automatic observe();
        logic was_idle;
        was_idle = !m_active;
        chk("in_ready", 32'(bus.in_ready), 32'(m_accepting && (!bus.out_valid || bus.out_ready)));
        chk("coef_en", 32'(bus.coef_en), 32'(bus.in_valid && bus.in_ready));
        chk("busy", 32'(busy), 32'(m_active));
        chk("frames_done", 32'(frames_done), 32'(m_frames_done));
        if (prev_stall)
            chk("out_hold", {22'd0, bus.out_valid, bus.out_last, bus.out_sample},
                {22'd0, 1'b1, prev_last, prev_sample});
        if (exp_q.size() == 0)
            chk("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
        else if (bus.out_valid)
            chk("out_data", {23'd0, bus.out_last, bus.out_sample}, {23'd0, exp_q[0].l, exp_q[0].s});
        if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;

        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
            if (exp_q[0].l) begin
                n_last++;
                if (m_frames_done != '1) m_frames_done++;
            end
            void'(exp_q.pop_front());
            n_out++;
            last_hs_sample = bus.out_sample;
            if (!m_accepting && exp_q.size() == 0) begin
                m_active    = 1'b0;
                m_stop_pend = 1'b0;
            end
        end

        if (stop && m_accepting) m_stop_pend = 1'b1;
        if (bus.in_valid && bus.in_ready) begin
            chk("coef_addr", 32'(bus.coef_addr), 32'(m_acc_idx));
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            exp_q.push_back('{s: DW'((int'(bus.in_sample) * int'(rom[m_acc_idx])) >> CW),
                              l: (m_acc_idx == N - 1)});
            if (m_acc_idx == N - 1) begin
                m_acc_idx = 0;
                m_frames_in++;
                if ((m_target != 0 && m_frames_in == m_target) || m_stop_pend) m_accepting = 1'b0;
            end else begin
                m_acc_idx++;
            end
            rom_q = rom[bus.coef_addr];
        end else begin
            rom_q = CW'($urandom);
        end

        if (start && was_idle) begin
            m_active      = 1'b1;
            m_accepting   = 1'b1;
            m_acc_idx     = 0;
            m_frames_in   = 0;
            m_target      = int'(num_frames);
            m_frames_done = '0;
            m_stop_pend   = 1'b0;
        end
        prev_stall  = bus.out_valid && !bus.out_ready;
        prev_last   = bus.out_last;
        prev_sample = bus.out_sample;
    endtask

    task automatic cycle();
        bus.coef_data = rom_q;
        #1;
        observe();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0; stop = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    // rmode: 0 always ready, 1 toggling 1010..., 2 random
    task automatic run_frames(input int num, input int pv, input int rmode, input int fixed,
                              input int stop_f, input int stop_i, input int budget);
        int spent;
        bit stopped;
        spent = 0; stopped = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        start = 1'b1; num_frames = FW'(num);
        cycle();
        start = 1'b0;
        while (m_active && spent < budget) begin
            bus.in_valid  = ($urandom_range(99) < pv);
            bus.in_sample = (fixed >= 0) ? DW'(fixed) : DW'($urandom);
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (spent % 2 == 0);
                default: bus.out_ready = ($urandom_range(99) < 70);
            endcase
            num_frames = FW'($urandom_range(7));
            start      = ($urandom_range(15) == 0);
            stop = (!stopped && stop_f >= 0 && m_accepting &&
                    m_frames_in == stop_f && m_acc_idx == stop_i);
            if (stop) stopped = 1;
            cycle();
            spent++;
        end
        start = 1'b0; stop = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("run_completes", 32'(busy), 32'd0);
    endtask

    initial begin
        arith_t tbl[7];
        int     o0, l0, guard;

        tbl[0] = '{200, 'hFFFF, 199};
        tbl[1] = '{255, 'h0000, 0};
        tbl[2] = '{255, 'h8000, 127};
        tbl[3] = '{255, 'hFFFF, 254};
        tbl[4] = '{1,   'hFFFF, 0};
        tbl[5] = '{128, 'h8000, 64};
        tbl[6] = '{100, 'h4000, 25};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_frames = '0;
        bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b1; bus.coef_data = '0;
        rom_q = '0;
        for (int i = 0; i < N; i++) rom[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_coef_en", 32'(bus.coef_en), 32'd0);
        chk("rst_out_sample", 32'(bus.out_sample), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_coef_addr", 32'(bus.coef_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        // Arithmetic vectors, one full single frame per row
        for (int i = 0; i < 7; i++) begin
            for (int a = 0; a < N; a++) rom[a] = CW'(tbl[i].coef);
            o0 = n_out; l0 = n_last; first_acc_cyc = -1; first_out_cyc = -1;
            run_frames(1, 100, 0, tbl[i].sample, -1, -1, 100);
            chk($sformatf("arith_row%0d", i), 32'(last_hs_sample), 32'(tbl[i].expv));
            chk("arith_out_count", 32'(n_out - o0), 32'(N));
            chk("arith_last_count", 32'(n_last - l0), 32'd1);
            chk("arith_frames_done", 32'(frames_done), 32'd1);
            if (i == 0) chk("latency", 32'(first_out_cyc - first_acc_cyc), 32'd2);
        end

        for (int a = 0; a < N; a++) rom[a] = CW'($urandom);
        o0 = n_out;
        run_frames(1, 100, 1, -1, -1, -1, 100);
        chk("backpressure_count", 32'(n_out - o0), 32'(N));

        o0 = n_out; l0 = n_last;
        run_frames(0, 100, 0, -1, 1, 3, 200);
        chk("stop_frames_done", 32'(frames_done), 32'd2);
        chk("stop_last_count", 32'(n_last - l0), 32'd2);
        idle_cycles(5);

        run_frames(0, 60, 2, -1, 0, 0, 200);
        chk("stop_idx0_frames_done", 32'(frames_done), 32'd1);

        o0 = n_out; l0 = n_last;
        run_frames(3, 70, 2, -1, -1, -1, 400);
        chk("multi_frames_done", 32'(frames_done), 32'd3);
        chk("multi_out_count", 32'(n_out - o0), 32'(3 * N));
        chk("multi_last_count", 32'(n_last - l0), 32'd3);

        for (int r = 0; r < 6; r++) begin
            int num;
            for (int a = 0; a < N; a++) rom[a] = CW'($urandom);
            num = $urandom_range(3);
            if (num == 0) run_frames(0, 80, 2, -1, $urandom_range(2), $urandom_range(N - 1), 500);
            else          run_frames(num, 80, 2, -1, -1, -1, 500);
            idle_cycles(2);
        end

        // Asynchronous reset in the middle of a frame
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        start = 1'b1; num_frames = '0;
        cycle();
        start = 1'b0;
        guard = 0;
        while (!(m_frames_in == 0 && m_acc_idx == 5) && guard < 50) begin
            bus.in_valid = 1'b1; bus.in_sample = DW'($urandom);
            cycle();
            guard++;
        end
        bus.coef_data = rom_q;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_coef_en", 32'(bus.coef_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_coef_addr", 32'(bus.coef_addr), 32'd0);
        chk("arst_frames_done", 32'(frames_done), 32'd0);
        @(negedge clk);
        idle_cycles(4);
        run_frames(1, 100, 0, -1, -1, -1, 100);
        chk("resume_frames_done", 32'(frames_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hann_frame_sequencer.md
Name: hann_frame_sequencer

Overview:
- Controller that sequences the Hann windowing datapath for the transcription front end.
- Accepts a sample stream and steps a window index 0..SAMPLE_COUNT-1 once per accepted sample.
- Drives the external coefficient ROM, multiplies each sample by its coefficient and emits a framed stream to the FFT with a last flag on each frame's final sample.
- Owns frame counting, start/stop control and end-to-end backpressure.

Parameters:
- DATA_WIDTH, 8, sample width in and out (unsigned).
- COEF_WIDTH, 16, ROM coefficient width; unsigned Q0.COEF_WIDTH, coef = round(w[n]*(2^COEF_WIDTH-1)).
- SAMPLE_COUNT, 4096, samples per frame; power of two, >= 4.
- FRAME_CNT_WIDTH, 16, width of the frame request and frame counter.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous, active-low reset.
- start_in, input, 1, one-cycle pulse; arms the sequencer when IDLE.
- stop_in, input, 1, one-cycle pulse; finish the current frame, then stop.
- num_frames_in, input, FRAME_CNT_WIDTH, frames to run; 0 = continuous. Sampled on start.
- in_valid, input, 1, sample valid.
- in_ready, output, 1, sequencer accepts a sample.
- in_sample, input, DATA_WIDTH, raw sample.
- coef_en, output, 1, ROM read enable.
- coef_addr, output, $clog2(SAMPLE_COUNT), ROM address = window index.
- coef_data, input, COEF_WIDTH, ROM data; valid 1 cycle after coef_en.
- out_valid, output, 1, windowed sample valid.
- out_ready, input, 1, downstream accepts.
- out_sample, output, DATA_WIDTH, windowed sample.
- out_last, output, 1, marks index SAMPLE_COUNT-1.
- busy, output, 1, state != IDLE.
- frames_done, output, FRAME_CNT_WIDTH, frames fully emitted since last start; saturates.

Behaviour:
- Reset (rst_in low, async):
  - state = IDLE, index = 0, frames_done = 0.
  - All pipeline valids = 0; out_valid, out_last, in_ready, coef_en and busy = 0; out_sample = 0.
  - Reset mid-frame discards all in-flight data; no partial frame is reported.
- States:
  - IDLE -> RUN on start_in: clears index and frames_done, latches num_frames_in. start_in is ignored outside IDLE.
  - RUN -> DRAIN when the sample at index SAMPLE_COUNT-1 is accepted and either the requested frame count is reached or a stop is pending.
  - DRAIN -> IDLE when the last sample is accepted at the output (out_valid && out_ready && out_last).
- stop_in:
  - In RUN it sets stop_pending; stop_pending clears on entry to IDLE.
  - If stop_in arrives at index 0 with no sample yet accepted in the frame, the current frame still runs in full. Frames are never truncated.
- Pipeline:
  - advance = !out_valid || out_ready.
  - in_ready = (state == RUN) && advance.
  - coef_en = in_ready && in_valid; coef_addr = index.
  - Stage 1 registers the sample and last flag alongside the ROM access.
  - Stage 2 registers out_sample = (sample * coef_data) >> COEF_WIDTH, truncated to DATA_WIDTH. The result never exceeds the input sample, so there is no overflow.
  - Latency: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 sample/cycle.
  - When advance = 0, all stages hold, coef_en = 0, and coef_data is not re-sampled. Stage 1 captures ROM data only on the cycle after coef_en.
- Index:
  - Increments on each accepted sample.
  - Wraps from SAMPLE_COUNT-1 to 0. out_last is set on the sample accepted at SAMPLE_COUNT-1.
- Frame counting:
  - frames_done increments on each output handshake with out_last set, saturating at all-ones.
  - In continuous mode (num_frames_in = 0) the sequencer runs until stop_in.
- Output stability: out_valid, out_sample and out_last hold stable while out_valid && !out_ready.
- busy is high in RUN and DRAIN.

Test Plan:
- Single frame, no stall:
  - Stimulus: SAMPLE_COUNT=8, start with num_frames_in=1, in_sample=200 every cycle, ROM returns 0xFFFF at all addresses.
  - Required: 8 outputs of 199, the first 2 cycles after the first accept. out_last only on the 8th. frames_done=1, then IDLE, busy=0.
- Backpressure:
  - Stimulus: out_ready toggling 1010…, in_valid held high.
  - Required: no sample lost or duplicated; coef_addr sequence 0..7 is monotonic; out_sample holds during stalls; coef_en=0 in stalled cycles.
- Arithmetic:
  - Stimulus: sample=255 against coef=0, 0x8000, 0xFFFF.
  - Required: out_sample = 0, 127, 254 respectively.
- Continuous mode with stop:
  - Stimulus: num_frames_in=0; stop_in pulsed at index 3 of frame 2.
  - Required: frame 2 completes to index 7 with out_last, frames_done=2, return to IDLE. No further in_ready.
- Multi-frame wrap:
  - Stimulus: num_frames_in=3.
  - Required: coef_addr wraps 7->0 twice, 24 outputs, 3 out_last pulses, frames_done=3.
- Async reset mid-frame:
  - Stimulus: rst_in low at index 5, off clock edge.
  - Required: out_valid, in_ready, coef_en and busy drop immediately. After release: IDLE, index 0, frames_done 0; start_in is needed to resume.
